seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 144 ++++++++++++++
 tb/tb_seg_scan_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan decoder: samples a multiplexed 4-digit display bus,
// debounces each strobe/pattern pair and commits decoded hex digits.
module seg_scan_decoder #(
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_sel,
  input  logic        err_clr,
  output logic [15:0] hex_out,
  output logic [3:0]  digit_valid,
  output logic        upd,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HOLD
  } state_t;

  state_t      st, st_nx;
  logic [10:0] smp, prv;
  logic [3:0]  cnt, cnt_nx;
  logic [3:0]  sel;
  logic [6:0]  pat;
  logic        one_hot, multi, same;
  logic        commit;
  logic        blank, dec_ok;
  logic [3:0]  dec_val;
  logic        err_set;

  assign sel     = smp[10:7];
  assign pat     = smp[6:0];
  assign multi   = |(sel & (sel - 4'd1));
  assign one_hot = (sel != 4'd0) && !multi;
  assign same    = (smp == prv);
  assign blank   = (pat == 7'b0000000);

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (pat)
      7'b1111110: dec_val = 4'h0;
      7'b0110000: dec_val = 4'h1;
      7'b1101101: dec_val = 4'h2;
      7'b1111001: dec_val = 4'h3;
      7'b0110011: dec_val = 4'h4;
      7'b1011011: dec_val = 4'h5;
      7'b1011111: dec_val = 4'h6;
      7'b1110000: dec_val = 4'h7;
      7'b1111111: dec_val = 4'h8;
      7'b1110011: dec_val = 4'h9;
      7'b1110111: dec_val = 4'hA;
      7'b0011111: dec_val = 4'hB;
      7'b0001101: dec_val = 4'hC;
      7'b0111101: dec_val = 4'hD;
      7'b1101111: dec_val = 4'hE;
      7'b1000111: dec_val = 4'hF;
      default:    dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    commit = 1'b0;
    unique case (st)
      IDLE: begin
        if (one_hot) begin
          cnt_nx = 4'd1;
          st_nx  = TRACK;
        end
      end
      TRACK: begin
        if (same) begin
          cnt_nx = cnt + 4'd1;
          if (cnt_nx == 4'(STABLE_CNT)) begin
            commit = 1'b1;
            st_nx  = HOLD;
          end
        end else if (one_hot) begin
          cnt_nx = 4'd1;
        end else begin
          cnt_nx = 4'd0;
          st_nx  = IDLE;
        end
      end
      HOLD: begin
        if (!same) begin
          if (one_hot) begin
            cnt_nx = 4'd1;
            st_nx  = TRACK;
          end else begin
            cnt_nx = 4'd0;
            st_nx  = IDLE;
          end
        end
      end
      default: begin
        cnt_nx = 4'd0;
        st_nx  = IDLE;
      end
    endcase
  end

  // An illegal pattern still parks in HOLD so it is flagged only once
  assign err_set = multi || (commit && !blank && !dec_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      cnt         <= 4'd0;
      smp         <= 11'd0;
      prv         <= 11'd0;
      hex_out     <= 16'h0000;
      digit_valid <= 4'b0000;
      upd         <= 1'b0;
      err         <= 1'b0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
      smp <= {dig_sel, seg_in};
      prv <= smp;
      upd <= commit && (blank || dec_ok);
      if (err_set)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (commit && sel[i]) begin
          if (blank) begin
            digit_valid[i] <= 1'b0;
          end else if (dec_ok) begin
            hex_out[4*i +: 4] <= dec_val;
            digit_valid[i]    <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: commit latency, single-commit hold,
// scan, error flag, debounce rejection, reset and blank handling.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic        err_clr;
  logic [15:0] hex_out;
  logic [3:0]  digit_valid;
  logic        upd;
  logic        err;

  int checks = 0;
  int errors = 0;
  int pulses;

  localparam logic [6:0] P1 = 7'b0110000;
  localparam logic [6:0] P3 = 7'b1111001;
  localparam logic [6:0] P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1110011;
  localparam logic [6:0] PA = 7'b1110111;
  localparam logic [6:0] PC = 7'b0001101;
  localparam logic [6:0] PE = 7'b1101111;
  localparam logic [6:0] PF = 7'b1000111;
  localparam logic [6:0] BAD = 7'b1010101;

  seg_scan_decoder #(.STABLE_CNT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .err_clr     (err_clr),
    .hex_out     (hex_out),
    .digit_valid (digit_valid),
    .upd         (upd),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] d, input logic [6:0] s);
    dig_sel = d;
    seg_in  = s;
  endtask

  initial begin
    rst = 1'b1;
    err_clr = 1'b0;
    drive(4'b1111, P8);
    tick();
    tick();
    chk("rst_hex", hex_out, 16'h0000);
    chk("rst_valid", 16'(digit_valid), 16'h0);
    chk("rst_upd", 16'(upd), 16'h0);
    chk("rst_err", 16'(err), 16'h0);

    // first commit: digit 0 = 3 after edge k+4
    rst = 1'b0;
    drive(4'b0001, P3);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += int'(upd);
    end
    chk("lat_early_upd", 16'(pulses), 16'd0);
    tick();
    chk("lat_upd", 16'(upd), 16'h1);
    chk("lat_hex", hex_out, 16'h0003);
    chk("lat_valid", 16'(digit_valid), 16'h1);

    // stable hold commits once
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      pulses += int'(upd);
    end
    chk("hold_pulses", 16'(pulses), 16'd0);

    drive(4'b0001, P1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += int'(upd);
    end
    chk("chg_early", 16'(pulses), 16'd0);
    tick();
    chk("chg_upd", 16'(upd), 16'h1);
    chk("chg_hex", hex_out, 16'h0001);

    // four-digit scan
    for (int d = 0; d < 4; d++) begin
      case (d)
        0: drive(4'b0001, PC);
        1: drive(4'b0010, PA);
        2: drive(4'b0100, PF);
        default: drive(4'b1000, PE);
      endcase
      repeat (6) tick();
      drive(4'b0000, 7'd0);
      tick();
    end
    chk("scan_hex", hex_out, 16'hEFAC);
    chk("scan_valid", 16'(digit_valid), 16'hF);
    chk("scan_err", 16'(err), 16'h0);

    // illegal pattern on digit 2
    drive(4'b0100, BAD);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pulses += int'(upd);
    end
    chk("bad_err", 16'(err), 16'h1);
    chk("bad_hex", hex_out, 16'hEFAC);
    chk("bad_valid", 16'(digit_valid), 16'hF);
    chk("bad_upd", 16'(pulses), 16'd0);

    drive(4'b0000, 7'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", 16'(err), 16'h0);

    // two strobes at once
    drive(4'b0011, 7'd0);
    tick();
    drive(4'b0000, 7'd0);
    chk("multi_lag", 16'(err), 16'h0);
    tick();
    chk("multi_err", 16'(err), 16'h1);
    err_clr = 1'b1;
    tick();
    chk("clr2_err", 16'(err), 16'h0);

    // set beats clear
    drive(4'b0011, 7'd0);
    tick();
    drive(4'b0000, 7'd0);
    tick();
    chk("set_wins", 16'(err), 16'h1);
    tick();
    err_clr = 1'b0;
    chk("clr3_err", 16'(err), 16'h0);

    // blank on digit 1
    drive(4'b0010, 7'd0);
    repeat (4) tick();
    chk("blank_early", 16'(upd), 16'h0);
    tick();
    chk("blank_upd", 16'(upd), 16'h1);
    chk("blank_valid", 16'(digit_valid), 16'hD);
    chk("blank_hex", hex_out, 16'hEFAC);
    chk("blank_err", 16'(err), 16'h0);

    // toggling every 3 cycles never settles
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive(4'b0001, i[0] ? P9 : P8);
      repeat (3) begin
        tick();
        pulses += int'(upd);
      end
    end
    chk("tog_upd", 16'(pulses), 16'd0);
    chk("tog_hex", hex_out, 16'hEFAC);

    // reset at run count 3
    drive(4'b0001, P3);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_hex", hex_out, 16'h0000);
    chk("mid_valid", 16'(digit_valid), 16'h0);
    chk("mid_upd", 16'(upd), 16'h0);
    chk("mid_err", 16'(err), 16'h0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += int'(upd);
    end
    chk("fresh_early", 16'(pulses), 16'd0);
    tick();
    chk("fresh_upd", 16'(upd), 16'h1);
    chk("fresh_hex", hex_out, 16'h0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
